// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter
// Two-requester read arbiter (icache = requester 0, dcache = requester 1) in
// front of one shared memory read bus. A winner keeps the bus for a whole
// cacheline burst of BEATS_PER_BURST accepted beats. Ties are broken
// round-robin against the owner of the previous burst.
module mem_read_arbiter #(
    parameter int ADDR_SIZE_BITS  = 32,
    parameter int DATA_SIZE_BITS  = 32,
    parameter int BEATS_PER_BURST = 4
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req0_stbr,
    input  logic [ADDR_SIZE_BITS-1:0] req0_addr_read,
    output logic [DATA_SIZE_BITS-1:0] req0_data_read,
    output logic                      req0_ackr,

    input  logic                      req1_stbr,
    input  logic [ADDR_SIZE_BITS-1:0] req1_addr_read,
    output logic [DATA_SIZE_BITS-1:0] req1_data_read,
    output logic                      req1_ackr,

    output logic                      bus_stbr,
    output logic [ADDR_SIZE_BITS-1:0] bus_addr_read,
    input  logic [DATA_SIZE_BITS-1:0] bus_data_read,
    input  logic                      bus_ackr,

    output logic [1:0]                grant,
    output logic                      busy
);

    localparam int CNT_W = $clog2(BEATS_PER_BURST);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_BURST - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] beat_q, beat_d;
    // 1 means requester 1 finished the most recent burst.
    logic             last_owner_q, last_owner_d;

    // A beat only counts when the bus actually had a live strobe; a stray
    // bus_ackr with bus_stbr low is ignored entirely.
    logic             beat_acc;

    assign beat_acc = bus_ackr & bus_stbr;

    // State, beat counter and round-robin history; reset abandons any burst.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            last_owner_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            last_owner_q <= last_owner_d;
        end
    end

    // Next-state: arbitrate only from IDLE, release only on the final beat.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        last_owner_d = last_owner_q;
        case (state_q)
            IDLE: begin
                beat_d = '0;
                if (req0_stbr && req1_stbr) begin
                    state_d = last_owner_q ? OWN0 : OWN1;
                end else if (req0_stbr) begin
                    state_d = OWN0;
                end else if (req1_stbr) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (beat_acc) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d      = IDLE;
                        beat_d       = '0;
                        last_owner_d = (state_q == OWN1);
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                beat_d  = '0;
            end
        endcase
    end

    // Outputs: the owner is muxed straight onto the bus; everything else is 0.
    always_comb begin
        bus_stbr       = 1'b0;
        bus_addr_read  = '0;
        grant          = 2'b00;
        req0_ackr      = 1'b0;
        req1_ackr      = 1'b0;
        req0_data_read = '0;
        req1_data_read = '0;
        case (state_q)
            OWN0: begin
                grant          = 2'b01;
                bus_stbr       = req0_stbr;
                bus_addr_read  = req0_addr_read;
                req0_ackr      = bus_ackr & req0_stbr;
                req0_data_read = bus_data_read;
            end
            OWN1: begin
                grant          = 2'b10;
                bus_stbr       = req1_stbr;
                bus_addr_read  = req1_addr_read;
                req1_ackr      = bus_ackr & req1_stbr;
                req1_data_read = bus_data_read;
            end
            default: begin
                grant = 2'b00;
            end
        endcase
        busy = |grant;
    end

endmodule
